// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS core's EX-stage blocks.
//   - ALUop / Funct decode constants for the R-type path
//   - ALUSel encodings, so ALU control and the mul/div unit decode from one source
//   - state encoding for the iterative multiply/divide FSM
package mips_pkg;

   localparam logic [2:0] ALUOP_RTYPE = 3'b001;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   localparam logic [3:0] ALUSEL_AND = 4'b0000;
   localparam logic [3:0] ALUSEL_OR  = 4'b0001;
   localparam logic [3:0] ALUSEL_ADD = 4'b0010;
   localparam logic [3:0] ALUSEL_SUB = 4'b0110;
   localparam logic [3:0] ALUSEL_SLT = 4'b0111;
   localparam logic [3:0] ALUSEL_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } mdu_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational iteration of the multiply/divide datapath.
//   mode_div = 0 : shift-add multiply step on {hi,lo}; lo holds the multiplier,
//                  opnd is the multiplicand magnitude.
//   mode_div = 1 : restoring divide step; hi is the partial remainder, lo holds
//                  the dividend shifting out / quotient shifting in, opnd is the
//                  divisor magnitude.
// Ports: mode_div, hi_in[WIDTH:0], lo_in[WIDTH-1:0], opnd[WIDTH-1:0] in;
//        hi_out[WIDTH:0], lo_out[WIDTH-1:0] out.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             mode_div,
   input  logic [WIDTH:0]   hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH:0]   hi_out,
   output logic [WIDTH-1:0] lo_out
);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH+1:0] trial_s;

   // single iteration: add-and-shift-right for multiply, shift-and-trial-subtract for divide
   always_comb begin
      // hi_in[WIDTH] is always zero in multiply mode, so the add keeps the carry in sum_s[WIDTH]
      sum_s     = hi_in + (lo_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      shifted_s = {hi_in[WIDTH-1:0], lo_in[WIDTH-1]};
      trial_s   = {1'b0, shifted_s} - {2'b00, opnd};
      if (mode_div) begin
         if (trial_s[WIDTH+1]) begin
            // trial went negative: restore, quotient bit 0
            hi_out = shifted_s;
            lo_out = {lo_in[WIDTH-2:0], 1'b0};
         end else begin
            hi_out = trial_s[WIDTH:0];
            lo_out = {lo_in[WIDTH-2:0], 1'b1};
         end
      end else begin
         hi_out = {1'b0, sum_s[WIDTH:1]};
         lo_out = {sum_s[0], lo_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with the HI/LO register pair, plus
// MFHI/MFLO read-out and MTHI/MTLO writes.
// Ports: clk, rst_n (async active-low), start, ALUop[2:0], Funct[5:0], A, B in;
//        busy, done (1-cycle), dz (sticky divide-by-zero), HI, LO, Result out.
// Operations take WIDTH+1 edges from acceptance to HI/LO update.
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       ALUop,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] Result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   mdu_state_t state_r, state_nx_s;

   logic             rtype_s, is_mt_s, is_mul_s, is_div_s, is_signed_s;
   logic             accept_op_s, accept_mt_s;
   logic             load_s, step_s, fix_s;
   logic             a_neg_s, b_neg_s;
   logic [WIDTH-1:0] a_mag_s, b_mag_s;

   logic [CW-1:0]    cnt_r;
   logic [WIDTH:0]   acc_hi_r, iter_hi_s;
   logic [WIDTH-1:0] acc_lo_r, iter_lo_s;
   logic [WIDTH-1:0] opnd_r, a_r;
   logic             mode_div_r, neg_q_r, neg_r_r, div_zero_r;

   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s, fix_hi_s, fix_lo_s;

   logic             busy_r, done_r, dz_r;
   logic [WIDTH-1:0] hi_r, lo_r;

   // instruction decode and acceptance
   always_comb begin
      is_mt_s     = 1'b0;
      is_mul_s    = 1'b0;
      is_div_s    = 1'b0;
      is_signed_s = 1'b0;
      rtype_s     = start && (ALUop == ALUOP_RTYPE) && !busy_r;
      case (Funct)
         FUNCT_MTHI, FUNCT_MTLO: is_mt_s = 1'b1;
         FUNCT_MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
         FUNCT_MULTU: is_mul_s = 1'b1;
         FUNCT_DIV:   begin is_div_s = 1'b1; is_signed_s = 1'b1; end
         FUNCT_DIVU:  is_div_s = 1'b1;
         default:     is_mt_s = 1'b0;
      endcase
      accept_op_s = rtype_s && (is_mul_s || is_div_s);
      accept_mt_s = rtype_s && is_mt_s;
   end

   // operand magnitudes; unsigned ops never count as negative
   always_comb begin
      a_neg_s = is_signed_s && A[WIDTH-1];
      b_neg_s = is_signed_s && B[WIDTH-1];
      a_mag_s = a_neg_s ? -A : A;
      b_mag_s = b_neg_s ? -B : B;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nx_s;
   end

   // FSM next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: state_nx_s = accept_op_s ? ST_RUN : ST_IDLE;
         ST_RUN:  state_nx_s = (cnt_r == CNT_LAST) ? ST_FIX : ST_RUN;
         ST_FIX:  state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // FSM control outputs
   always_comb begin
      load_s = 1'b0;
      step_s = 1'b0;
      fix_s  = 1'b0;
      case (state_r)
         ST_IDLE: load_s = accept_op_s;
         ST_RUN:  step_s = 1'b1;
         ST_FIX:  fix_s  = 1'b1;
         default: load_s = 1'b0;
      endcase
   end

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .mode_div (mode_div_r),
      .hi_in    (acc_hi_r),
      .lo_in    (acc_lo_r),
      .opnd     (opnd_r),
      .hi_out   (iter_hi_s),
      .lo_out   (iter_lo_s)
   );

   // operand latch and iteration accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r      <= {CW{1'b0}};
         acc_hi_r   <= {(WIDTH+1){1'b0}};
         acc_lo_r   <= {WIDTH{1'b0}};
         opnd_r     <= {WIDTH{1'b0}};
         a_r        <= {WIDTH{1'b0}};
         mode_div_r <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         div_zero_r <= 1'b0;
      end else if (load_s) begin
         cnt_r      <= {CW{1'b0}};
         acc_hi_r   <= {(WIDTH+1){1'b0}};
         acc_lo_r   <= is_div_s ? a_mag_s : b_mag_s;
         opnd_r     <= is_div_s ? b_mag_s : a_mag_s;
         a_r        <= A;
         mode_div_r <= is_div_s;
         neg_q_r    <= a_neg_s ^ b_neg_s;
         neg_r_r    <= a_neg_s;
         div_zero_r <= (B == {WIDTH{1'b0}});
      end else if (step_s) begin
         cnt_r    <= cnt_r + CNT_ONE;
         acc_hi_r <= iter_hi_s;
         acc_lo_r <= iter_lo_s;
      end
   end

   // sign fix-up of the finished magnitudes; zero divisor overrides the divide result
   always_comb begin
      prod_s = {acc_hi_r[WIDTH-1:0], acc_lo_r};
      if (neg_q_r) prod_s = -prod_s;
      quo_s = neg_q_r ? -acc_lo_r : acc_lo_r;
      rem_s = neg_r_r ? -acc_hi_r[WIDTH-1:0] : acc_hi_r[WIDTH-1:0];
      if (!mode_div_r) begin
         fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
         fix_lo_s = prod_s[WIDTH-1:0];
      end else if (div_zero_r) begin
         fix_hi_s = a_r;
         fix_lo_s = {WIDTH{1'b1}};
      end else begin
         fix_hi_s = rem_s;
         fix_lo_s = quo_s;
      end
   end

   // architectural HI/LO, status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r   <= {WIDTH{1'b0}};
         lo_r   <= {WIDTH{1'b0}};
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
      end else begin
         busy_r <= (state_nx_s != ST_IDLE);
         done_r <= fix_s;
         // FIX and an MT accept can never coincide: MT needs busy low
         if (fix_s) begin
            hi_r <= fix_hi_s;
            lo_r <= fix_lo_s;
            if (mode_div_r) dz_r <= div_zero_r;
         end else if (accept_mt_s) begin
            if (Funct == FUNCT_MTHI) hi_r <= A;
            else                     lo_r <= A;
         end
      end
   end

   // MFHI/MFLO read-out, combinational from current HI/LO
   always_comb begin
      if ((ALUop == ALUOP_RTYPE) && (Funct == FUNCT_MFHI))      Result = hi_r;
      else if ((ALUop == ALUOP_RTYPE) && (Funct == FUNCT_MFLO)) Result = lo_r;
      else                                                      Result = {WIDTH{1'b0}};
   end

   assign busy = busy_r;
   assign done = done_r;
   assign dz   = dz_r;
   assign HI   = hi_r;
   assign LO   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): the driver pushes hand-computed
// expected HI/LO/dz and the expected done cycle; a monitor pops on every done.
module tb_muldiv_unit;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [2:0]  ALUop;
   logic [5:0]  Funct;
   logic [31:0] A, B;
   logic        busy, done, dz;
   logic [31:0] HI, LO, Result;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ALUop(ALUop), .Funct(Funct),
      .A(A), .B(B), .busy(busy), .done(done), .dz(dz), .HI(HI), .LO(LO),
      .Result(Result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // drive one accepted-candidate instruction for one edge; optionally queue the expected result
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] eh, input logic [31:0] el, input logic ed);
      exp_t e;
      start = 1'b1; ALUop = 3'b001; Funct = f; A = a; B = b;
      if (push) begin
         e.hi = eh; e.lo = el; e.dz = ed; e.cyc = cyc + 34;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout actual=0 expected=1");
      end
   endtask

   // monitor: every done pulse must match the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("hi", {32'h0, HI}, {32'h0, e.hi});
               chk("lo", {32'h0, LO}, {32'h0, e.lo});
               chk("dz", {63'h0, dz}, {63'h0, e.dz});
               chk("latency", 64'(cyc), 64'(e.cyc));
               chk("busy_in_done", {63'h0, busy}, 64'h0);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; ALUop = 3'b000; Funct = 6'b000000; A = 32'h0; B = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ALUop = 3'b001; Funct = F_MFHI;
      #1;
      chk("rst_hi", {32'h0, HI}, 64'h0);
      chk("rst_lo", {32'h0, LO}, 64'h0);
      chk("rst_flags", {61'h0, busy, done, dz}, 64'h0);
      chk("rst_result", {32'h0, Result}, 64'h0);
      @(negedge clk);

      issue(F_MULT, 32'hFFFFFFFD, 32'h5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      Funct = F_MFHI;
      #1;
      chk("busy_after_accept", {63'h0, busy}, 64'h1);
      chk("mfhi_old_during_busy", {32'h0, Result}, 64'h0);
      wait_done();

      issue(F_MULTU, 32'hFFFFFFFF, 32'h2, 1'b1, 32'h1, 32'hFFFFFFFE, 1'b0);
      wait_done();
      issue(F_DIV, 32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      wait_done();
      issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b0);
      wait_done();
      issue(F_DIVU, 32'h7, 32'h0, 1'b1, 32'h7, 32'hFFFFFFFF, 1'b1);
      wait_done();

      // MULT 6*7, a DIV arriving at edge +5 must be dropped
      issue(F_MULT, 32'h6, 32'h7, 1'b1, 32'h0, 32'h2A, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      issue(F_DIV, 32'd100, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("busy_after_drop", {63'h0, busy}, 64'h1);
      wait_done();
      // MTHI in the done cycle
      issue(F_MTHI, 32'h1234, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("mthi_hi", {32'h0, HI}, 64'h1234);
      chk("mthi_lo_kept", {32'h0, LO}, 64'h2A);
      chk("mthi_flags", {61'h0, busy, done, dz}, 64'h1);
      @(negedge clk);
      issue(F_MTLO, 32'h55, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("mtlo_lo", {32'h0, LO}, 64'h55);
      chk("mtlo_hi_kept", {32'h0, HI}, 64'h1234);

      // non-R-type ALUop must be ignored
      @(negedge clk);
      start = 1'b1; ALUop = 3'b000; Funct = F_MULT; A = 32'h3; B = 32'h3;
      @(posedge clk); #1;
      start = 1'b0;
      chk("ignored_not_rtype", {63'h0, busy}, 64'h0);
      @(negedge clk);

      issue(F_DIVU, 32'h9, 32'h3, 1'b1, 32'h0, 32'h3, 1'b0);
      wait_done();
      issue(F_DIVU, 32'h5, 32'h0, 1'b1, 32'h5, 32'hFFFFFFFF, 1'b1);
      wait_done();

      // reset in the middle of a DIV
      issue(F_DIV, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_hi", {32'h0, HI}, 64'h0);
      chk("midrst_lo", {32'h0, LO}, 64'h0);
      chk("midrst_flags", {61'h0, busy, done, dz}, 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(F_MULTU, 32'h3, 32'h4, 1'b1, 32'h0, 32'hC, 1'b0);
      wait_done();

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
